// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect input and IF/ID output handshake.
// master = fetch unit, slave = memory/decode/branch side.
interface instruction_fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;
  logic [15:0] fetch_count;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output halted,
    output fetch_count
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  halted,
    input  fetch_count
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC drives imem_addr, word captured into IF/ID register one edge later (1/cycle).
// Backpressure: out_valid & !out_ready stalls everything; a redirect always wins and costs one bubble.
module instruction_fetch_unit #(
  parameter int unsigned IMEM_DEPTH = 32,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  instruction_fetch_unit_if.master bus
);

  localparam logic [31:0] DEPTH_W    = 32'(IMEM_DEPTH);
  localparam logic [31:0] LAST_PC    = DEPTH_W - 32'd1;
  localparam logic [31:0] RST_PC_W   = 32'(RESET_PC);
  localparam logic        RESET_HALT = (RST_PC_W >= DEPTH_W);

  logic [31:0] pc_q,          pc_d;
  logic        out_valid_q,   out_valid_d;
  logic [31:0] out_instr_q,   out_instr_d;
  logic [31:0] out_pc_q,      out_pc_d;
  logic        halted_q,      halted_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  logic handshake;
  logic slot_free;

  assign handshake = out_valid_q & bus.out_ready;
  assign slot_free = ~out_valid_q | bus.out_ready;

  always_comb begin
    pc_d          = pc_q;
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;
    halted_d      = halted_q;
    fetch_count_d = fetch_count_q;

    if (bus.redirect_valid) begin
      // Any held word is either consumed by this cycle's handshake or squashed.
      pc_d        = bus.redirect_pc;
      out_valid_d = 1'b0;
      halted_d    = (bus.redirect_pc >= DEPTH_W);
    end else if (!halted_q && slot_free) begin
      out_instr_d = bus.imem_data;
      out_pc_d    = pc_q;
      out_valid_d = 1'b1;
      pc_d        = pc_q + 32'd1;
      halted_d    = (pc_q == LAST_PC);
      if (fetch_count_q != 16'hFFFF) begin
        fetch_count_d = fetch_count_q + 16'd1;
      end
    end else if (handshake) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RST_PC_W;
      out_valid_q   <= 1'b0;
      out_instr_q   <= 32'd0;
      out_pc_q      <= 32'd0;
      halted_q      <= RESET_HALT;
      fetch_count_q <= 16'd0;
    end else begin
      pc_q          <= pc_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_instr   = out_instr_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.halted      = halted_q;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage feeding the instruction memory reader: owns the program counter (word index), drives it as the memory address, captures the returned 32-bit instruction into an IF/ID output register with a valid/ready handshake, and accepts branch/jump redirects from later stages. Stops fetching after the last memory word and reports halt. Sits between the instruction memory and the decode stage.

## Interface
- IMEM_DEPTH, 32, number of instruction words; valid PCs are 0..IMEM_DEPTH-1
- RESET_PC, 0, word index loaded into the PC on reset
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_addr  out  32  word index to instruction memory; equals PC register (combinational from register)
- imem_data  in  32  instruction word for imem_addr, valid in the same cycle
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  32  target word index
- out_valid  out  1  out_instr/out_pc hold a fetched instruction
- out_ready  in  1  decode accepts the output this cycle
- out_instr  out  32  fetched instruction
- out_pc  out  32  word index of out_instr
- halted  out  1  fetching stopped (PC past last word)
- fetch_count  out  16  instructions captured since reset, saturating

## Operation
- Output slot is free when out_valid=0 or (out_valid=1 and out_ready=1).
- Priority per cycle: reset > redirect > capture > hold.
- Redirect (redirect_valid=1): PC <= redirect_pc; out_valid <= 0; imem_data ignored that cycle; halted <= (redirect_pc >= IMEM_DEPTH). A handshake in the same cycle (out_valid & out_ready) still counts as transferred.
- Capture (no redirect, halted=0, slot free): out_instr <= imem_data, out_pc <= PC, out_valid <= 1, PC <= PC+1, fetch_count <= fetch_count+1 (holds at 0xFFFF). If PC == IMEM_DEPTH-1: halted <= 1.
- Halted, no redirect: PC and out_instr/out_pc hold; if out_valid & out_ready then out_valid <= 0.
- Stall (out_valid=1, out_ready=0, no redirect): all state holds; out_instr/out_pc stable.
- PC arithmetic is 32-bit unsigned; no wrap occurs in normal flow because capture stops at IMEM_DEPTH-1.

## Timing
- Reset values: PC=RESET_PC (so imem_addr=RESET_PC), out_valid=0, out_instr=0, out_pc=0, fetch_count=0, halted=(RESET_PC >= IMEM_DEPTH).
- Reset asserted mid-operation clears everything immediately (asynchronous), independent of clk.
- Latency: word at PC=n appears on out_instr one cycle after the edge on which imem_addr=n and slot is free.
- Throughput: out_ready held 1 gives one instruction per cycle, no bubbles.
- Redirect penalty: one bubble cycle (out_valid=0) after the redirect edge; target instruction valid on the following edge.
- halted rises on the same edge that captures word IMEM_DEPTH-1; out_valid remains 1 until that word is accepted.

## Test plan
- Sequential: memory words 0..4 = 0x20010001..0x20010005, out_ready=1 -> out_instr 0x20010001..0x20010005 on five consecutive cycles, out_pc 0..4, fetch_count=5.
- Stall: out_ready=0 for 3 cycles while out_pc=2 -> out_instr/out_pc/imem_addr (3) stable, fetch_count unchanged; releasing out_ready resumes at out_pc=3 next cycle.
- Redirect: redirect_valid=1, redirect_pc=10 while out_pc=4 -> next cycle out_valid=0, imem_addr=10; following cycle out_pc=10, out_instr=word 10.
- End of memory: run from PC 29 with IMEM_DEPTH=32 -> captures 29,30,31, halted=1 on edge capturing 31, out_valid drops after word 31 accepted, imem_addr stays 32.
- Out-of-range redirect: redirect_pc=40 -> halted=1, out_valid=0, no capture; subsequent redirect_pc=0 clears halted and fetches word 0.
- Reset mid-run: assert rst_n=0 between edges at out_pc=7 -> immediately out_valid=0, imem_addr=RESET_PC, fetch_count=0, halted=0; after release fetch restarts at word 0.
